// File: rtl/bshift_pkg.sv
// bshift_pkg: shared definitions for the sequential barrel shift unit.
//   - BSHIFT_W : datapath width (fixed at 8, stage distances are 1/2/4)
//   - op_e     : shift operation encodings
//   - state_e  : control FSM state encoding
//   - carry_out: carry-out helper, compiled only when BSHIFT_CARRY_EN is defined
package bshift_pkg;

  localparam int BSHIFT_W = 8;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S4   = 3'd3,
    DONE = 3'd4
  } state_e;

`ifdef BSHIFT_CARRY_EN
  // The carry is the last bit pushed out of the word. It is derived
  // directly from the original operand rather than tracked through the
  // stages, so a zero shift amount simply yields 0.
  function automatic logic carry_out(input logic [BSHIFT_W-1:0] d,
                                     input logic [2:0] n,
                                     input op_e o);
    logic [2:0] idx;
    if (n == 3'd0) begin
      return 1'b0;
    end
    if (o == OP_LSL) begin
      idx = 3'(4'd8 - {1'b0, n});
    end else begin
      idx = n - 3'd1;
    end
    return d[idx];
  endfunction
`endif

endpackage

// File: rtl/bshift_seq_if.sv
// bshift_seq_if: request/result handshake bundle of the shift unit.
//   Request : in_valid, in_ready, data_in, shamt, op
//   Result  : out_valid, out_ready, data_out, zero, carry (carry only with
//             BSHIFT_CARRY_EN defined)
//   Modports: master = requester/consumer side, slave = shift unit.
interface bshift_seq_if;
  import bshift_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [BSHIFT_W-1:0] data_in;
  logic [2:0]          shamt;
  logic [1:0]          op;
  logic                out_valid;
  logic                out_ready;
  logic [BSHIFT_W-1:0] data_out;
  logic                zero;
`ifdef BSHIFT_CARRY_EN
  logic                carry;
`endif

  modport master (
    output in_valid, data_in, shamt, op, out_ready,
`ifdef BSHIFT_CARRY_EN
    input  carry,
`endif
    input  in_ready, out_valid, data_out, zero
  );

  modport slave (
    input  in_valid, data_in, shamt, op, out_ready,
`ifdef BSHIFT_CARRY_EN
    output carry,
`endif
    output in_ready, out_valid, data_out, zero
  );

endinterface

// File: rtl/bshift_stage.sv
// bshift_stage: one combinational stage of the logarithmic barrel shifter.
//   Parameter DIST : shift distance of this stage (1, 2 or 4)
//   data_i : input word
//   en_i   : apply the shift when 1, pass data_i through when 0
//   op_i   : LSL / LSR / ASR / ROR
//   data_o : stage output
module bshift_stage
  import bshift_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [BSHIFT_W-1:0] data_i,
  input  logic                en_i,
  input  op_e                 op_i,
  output logic [BSHIFT_W-1:0] data_o
);

  logic [BSHIFT_W-1:0] shifted;

  // Each output bit picks one of four candidates; the candidates that would
  // index outside the word are resolved to their fill value at elaboration.
  for (genvar i = 0; i < BSHIFT_W; i++) begin : g_bit
    logic lslBit, lsrBit, asrBit, rorBit;

    if (i >= DIST) begin : g_lsl_src
      assign lslBit = data_i[i-DIST];
    end else begin : g_lsl_fill
      assign lslBit = 1'b0;
    end

    if (i + DIST < BSHIFT_W) begin : g_rsh_src
      assign lsrBit = data_i[i+DIST];
      assign asrBit = data_i[i+DIST];
    end else begin : g_rsh_fill
      // ASR never alters bit 7, so bit 7 of any stage input still equals the
      // operand's sign bit.
      assign lsrBit = 1'b0;
      assign asrBit = data_i[BSHIFT_W-1];
    end

    assign rorBit = data_i[(i+DIST) % BSHIFT_W];

    always_comb begin
      case (op_i)
        OP_LSL:  shifted[i] = lslBit;
        OP_LSR:  shifted[i] = lsrBit;
        OP_ASR:  shifted[i] = asrBit;
        OP_ROR:  shifted[i] = rorBit;
        default: shifted[i] = lsrBit;
      endcase
    end
  end

  assign data_o = en_i ? shifted : data_i;

endmodule

// File: rtl/bshift_seq.sv
// bshift_seq: sequential 8-bit shift unit, one barrel stage per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : bshift_seq_if.slave (request and result handshakes)
// Optional feature: define BSHIFT_CARRY_EN to add the registered carry output.
// Flow: IDLE accepts a request, S1/S2/S4 apply the distance 1/2/4 stages,
// DONE presents the result until the consumer takes it.
module bshift_seq
  import bshift_pkg::*;
#(
  parameter int W = BSHIFT_W
) (
  input  logic        clk,
  input  logic        rst,
  bshift_seq_if.slave bus
);

  state_e         state_q, state_d;
  logic [W-1:0]   work_q, work_d;
  logic [2:0]     shamt_q, shamt_d;
  op_e            op_q, op_d;
  logic [W-1:0]   dataOut_q, dataOut_d;
  logic           zero_q, zero_d;
  logic           inReady, outValid;
  logic           accept;
  logic [W-1:0]   stage1Out, stage2Out, stage4Out;
`ifdef BSHIFT_CARRY_EN
  logic [W-1:0]   opnd_q, opnd_d;
  logic           carry_q, carry_d;
`endif

  assign accept = bus.in_valid & inReady;

  // All three stages read the working register; the state decides which
  // stage's result is written back.
  bshift_stage #(.DIST(1)) u_stage1 (
    .data_i (work_q),
    .en_i   (shamt_q[0]),
    .op_i   (op_q),
    .data_o (stage1Out)
  );

  bshift_stage #(.DIST(2)) u_stage2 (
    .data_i (work_q),
    .en_i   (shamt_q[1]),
    .op_i   (op_q),
    .data_o (stage2Out)
  );

  bshift_stage #(.DIST(4)) u_stage4 (
    .data_i (work_q),
    .en_i   (shamt_q[2]),
    .op_i   (op_q),
    .data_o (stage4Out)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      shamt_q   <= '0;
      op_q      <= OP_LSL;
      dataOut_q <= '0;
      zero_q    <= 1'b0;
`ifdef BSHIFT_CARRY_EN
      opnd_q    <= '0;
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      shamt_q   <= shamt_d;
      op_q      <= op_d;
      dataOut_q <= dataOut_d;
      zero_q    <= zero_d;
`ifdef BSHIFT_CARRY_EN
      opnd_q    <= opnd_d;
      carry_q   <= carry_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S4;
      S4:      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs come from registered state only.
  always_comb begin
    inReady  = 1'b0;
    outValid = 1'b0;
    case (state_q)
      IDLE:    inReady  = 1'b1;
      DONE:    outValid = 1'b1;
      default: ;
    endcase
  end

  // Datapath updates: latch on accept, step the working word through the
  // stages, and capture the result in S4 so it stays stable through DONE.
  always_comb begin
    work_d    = work_q;
    shamt_d   = shamt_q;
    op_d      = op_q;
    dataOut_d = dataOut_q;
    zero_d    = zero_q;
`ifdef BSHIFT_CARRY_EN
    opnd_d    = opnd_q;
    carry_d   = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d  = bus.data_in;
          shamt_d = bus.shamt;
          op_d    = op_e'(bus.op);
`ifdef BSHIFT_CARRY_EN
          opnd_d  = bus.data_in;
`endif
        end
      end
      S1: work_d = stage1Out;
      S2: work_d = stage2Out;
      S4: begin
        work_d    = stage4Out;
        dataOut_d = stage4Out;
        zero_d    = (stage4Out == '0);
`ifdef BSHIFT_CARRY_EN
        carry_d   = carry_out(opnd_q, shamt_q, op_q);
`endif
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.data_out  = dataOut_q;
  assign bus.zero      = zero_q;
`ifdef BSHIFT_CARRY_EN
  assign bus.carry     = carry_q;
`endif

endmodule

// File: doc/bshift_seq.md
# bshift_seq

Sequential 8-bit shift unit built around the three-stage logarithmic barrel shifter (distances 1, 2, 4). An operand, shift amount and operation are accepted over a valid/ready handshake. One shifter stage is applied per clock. The result is presented over a second valid/ready handshake to the downstream consumer (ALU writeback / display register). The block is the control and register stage that feeds the per-bit 4:1 selection network and holds its output.

## Interface
Parameters:
- `W`, 8: data width; only 8 is supported because stage distances are fixed at 1/2/4.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `in_valid`  in  1  request present
- `in_ready`  out  1  block can accept a request
- `data_in`  in  8  operand
- `shamt`  in  3  shift amount 0..7
- `op`  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `data_out`  out  8  shifted result
- `zero`  out  1  `data_out` == 0
- `carry`  out  1  last bit shifted out; present only with `BSHIFT_CARRY_EN`

## Operation
- FSM states: IDLE, S1, S2, S4, DONE.
- Reset (async, `rst`=1):
  - state = IDLE
  - working register = 0
  - `data_out`/`zero`/`carry`/`out_valid` = 0
  - `in_ready` = 1 once reset is released
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `data_in`, `shamt`, `op` into working registers, then go to S1.
- S1: if `shamt[0]`, apply distance-1 shift per `op`, else pass through; go to S2.
- S2: same as S1 with `shamt[1]` and distance 2; go to S4.
- S4: same with `shamt[2]` and distance 4; register the result into `data_out` and compute `zero`; go to DONE.
- DONE:
  - `out_valid`=1 and outputs are stable.
  - On `out_ready`: go to IDLE, and `out_valid` falls on the next edge.
  - `data_out` keeps its last value after the handshake.
- Fill rules:
  - LSL fills zeros at the LSB.
  - LSR fills zeros at the MSB.
  - ASR fills copies of the latched operand's bit 7.
  - ROR wraps LSBs into the MSB.
- `in_ready` is 0 in S1, S2, S4 and DONE. `in_valid` in those states is ignored and causes no state change.
- `shamt`=0 still takes the full latency; the result equals the operand.
- `carry`, when compiled in, is computed from the latched operand and `shamt`, independent of the stage path:
  - LSL: bit[8-n]
  - LSR/ASR/ROR: bit[n-1]
  - n=0: 0
- Reset mid-operation aborts immediately: the state returns to IDLE, the pending result is lost and the outputs are cleared.

## Timing
- Acceptance at edge k. `out_valid` is high after edge k+3, so latency is 3 cycles from accept to valid.
- The minimum initiation interval is 5 cycles (accept, S1, S2, S4, DONE with `out_ready` held high).
- `in_ready` and `out_valid` are decoded from registered state only. There are no combinational paths from `in_valid` or `out_ready` to any output.
- `out_valid` stays high with constant data for as long as `out_ready`=0.

## Configuration
- `BSHIFT_CARRY_EN` defined: the `carry` port exists, is registered at S4 alongside `data_out`, and is reset to 0.
- `BSHIFT_CARRY_EN` undefined: no `carry` port and no carry logic. All other behaviour is identical.

## Structure
- Package `bshift_pkg` holds:
  - op encodings (`OP_LSL`, `OP_LSR`, `OP_ASR`, `OP_ROR`)
  - FSM state encoding
  - width constant `BSHIFT_W`=8
- Sub-module `bshift_stage` (combinational):
  - inputs: data, enable, op
  - parameter: distance (1/2/4)
  - function: per-bit 4:1 selection among the four op fill behaviours
  - The top instantiates it once and muxes its distance by state; alternatively three instances selected by state.

## Test plan
- LSL `data_in`=0xB5, `shamt`=3 -> `data_out`=0xA8, `carry`=1, `zero`=0, `out_valid` 3 cycles after accept.
- ASR 0x96, `shamt`=2 -> 0xE5, `carry`=1. LSR 0x96, `shamt`=2 -> 0x25, `carry`=1.
- ROR 0x81, `shamt`=1 -> 0xC0, `carry`=1. LSR 0x81, `shamt`=7 -> 0x01, `carry`=0.
- LSR 0x00, `shamt`=0 -> 0x00, `zero`=1, `carry`=0, same 3-cycle latency.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 and new data -> `data_out` unchanged, `in_ready`=0, second request accepted only after return to IDLE.
- Assert `rst` during S2 -> outputs 0 and state IDLE immediately. The next request 0x01 LSL 1 -> 0x02.
